xip_spi_ctrl: RTL and testbench

//  Read-only SPI (mode 0) flash controller for the XIP pad group. It sequences xip_csn/xip_clk/xip_sdo
//  and samples xip_sdi. Each accepted request issues a READ (0x03) + 24-bit address and returns 32 data bits.

---
 rtl/xip_spi_ctrl_pkg.sv | 19 +
 rtl/xip_spi_ctrl_if.sv | 13 +
 rtl/xip_spi_ctrl_sck_gen.sv | 52 +++++
 rtl/xip_spi_ctrl.sv | 115 +++++++++++
 tb/tb_xip_spi_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xip_spi_ctrl_pkg.sv
// Shared constants, FSM state type and byte-order helper for the XIP SPI flash read controller.
package xip_pkg;

    localparam logic [7:0]  XIP_CMD_READ  = 8'h03;
    localparam int unsigned XIP_XFER_BITS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        GAP   = 2'd3
    } xip_state_e;

    // Flash returns bytes in address order; the first byte lands in the low lane.
    function automatic logic [31:0] xip_bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/xip_spi_ctrl_if.sv
// Request/response channel between the bus-side XIP bridge and the SPI flash controller.
interface xip_spi_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;

    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);

endinterface

// File: rtl/xip_spi_ctrl_sck_gen.sv
// SCK generator: CLK_DIV-cycle low then high phases while enabled, with a tick at the end of each high phase.
module xip_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic fall_tick,
    output logic sck_o
);

    localparam int unsigned     HC_W    = $clog2(CLK_DIV) + 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);

    logic [HC_W-1:0] hc_q, hc_d;
    logic            phase_q, phase_d;
    logic            sck_q;
    logic            half_end;

    assign half_end = (hc_q == HC_LAST);

    always_comb begin
        hc_d    = hc_q;
        phase_d = phase_q;
        if (!en) begin
            hc_d    = '0;
            phase_d = 1'b0;
        end else if (half_end) begin
            hc_d    = '0;
            phase_d = ~phase_q;
        end else begin
            hc_d = hc_q + 1'b1;
        end
    end

    // sck_q is the pad flop; it trails phase_q by one cycle like every other pad output.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q    <= '0;
            phase_q <= 1'b0;
            sck_q   <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            phase_q <= phase_d;
            sck_q   <= phase_q;
        end
    end

    assign fall_tick = en & phase_q & half_end;
    assign sck_o     = sck_q;

endmodule

// File: rtl/xip_spi_ctrl.sv
// Read-only SPI mode-0 flash controller: one READ (0x03) + 24-bit address, 32 data bits back per request.
module xip_spi_ctrl
    import xip_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    xip_spi_ctrl_if.slave        bus,
    output logic                 xip_csn,
    output logic                 xip_clk,
    output logic                 xip_sdo,
    input  logic                 xip_sdi
);

    localparam int unsigned GAP_W = $clog2(CS_GAP + 1);

    xip_state_e       state_q, state_d;
    logic [63:0]      tx_q, tx_d;
    logic [31:0]      rx_q, rx_d;
    logic [6:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ready_q, csn_q, sdo_q, rsp_valid_q;
    logic [31:0]      rsp_data_q;
    logic             accept, fall_tick, sck_en;

    assign accept = bus.req_valid & ready_q;
    assign sck_en = (state_q == SHIFT);

    xip_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (sck_en),
        .fall_tick (fall_tick),
        .sck_o     (xip_clk)
    );

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        gap_d     = gap_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = SHIFT;
                    tx_d      = {XIP_CMD_READ, bus.req_addr, 32'h0};
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (fall_tick) begin
                    rx_d      = {rx_q[30:0], xip_sdi};
                    tx_d      = {tx_q[62:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 7'd1;
                    if (bit_cnt_q == 7'(XIP_XFER_BITS - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = GAP;
                gap_d   = '0;
            end
            GAP: begin
                if (gap_q == GAP_W'(CS_GAP - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad and response flops decode the current state, so they trail the FSM by one cycle;
    // ready is built from the next state so it never lags an accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            gap_q       <= '0;
            ready_q     <= 1'b1;
            csn_q       <= 1'b1;
            sdo_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_q       <= gap_d;
            ready_q     <= (state_d == IDLE);
            csn_q       <= (state_q != SHIFT);
            sdo_q       <= (state_q == SHIFT) & tx_q[63];
            rsp_valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                rsp_data_q <= xip_bswap32(rx_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign xip_csn       = csn_q;
    assign xip_sdo       = sdo_q;

endmodule

// File: tb/tb_xip_spi_ctrl.sv
// Bench for xip_spi_ctrl: two instances (CLK_DIV 1 and 3) each talking to a behavioural READ-only flash.
module tb_xip_spi_ctrl;

    localparam int unsigned CS_GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rv  = '0;
    logic [23:0] ra [2];
    logic [1:0]  sdi = '0;
    logic        csn0, csn1, sck0, sck1, sdo0, sdo1;
    logic [1:0]  csn, sck, sdo, rdy, rspv;
    logic [31:0] rspd [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    xip_spi_ctrl_if bus0 ();
    xip_spi_ctrl_if bus1 ();

    assign bus0.req_valid = rv[0];
    assign bus0.req_addr  = ra[0];
    assign bus1.req_valid = rv[1];
    assign bus1.req_addr  = ra[1];
    assign csn  = {csn1, csn0};
    assign sck  = {sck1, sck0};
    assign sdo  = {sdo1, sdo0};
    assign rdy  = {bus1.req_ready, bus0.req_ready};
    assign rspv = {bus1.rsp_valid, bus0.rsp_valid};
    assign rspd[0] = bus0.rsp_data;
    assign rspd[1] = bus1.rsp_data;

    xip_spi_ctrl #(.CLK_DIV(1), .CS_GAP(CS_GAP)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0),
        .xip_csn(csn0), .xip_clk(sck0), .xip_sdo(sdo0), .xip_sdi(sdi[0])
    );

    xip_spi_ctrl #(.CLK_DIV(3), .CS_GAP(CS_GAP)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .xip_csn(csn1), .xip_clk(sck1), .xip_sdo(sdo1), .xip_sdi(sdi[1])
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int cd_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] mem_b(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Four consecutive flash bytes from address a (24-bit wrap), first byte in the low lane.
    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [31:0] w;
        logic [23:0] t;
        for (int b = 0; b < 4; b++) begin
            t = a + 24'(b);
            w[8*b +: 8] = mem_b(t);
        end
        return w;
    endfunction

    // Flash model state and per-transfer observations
    int          falls [2], rises [2], lo_cyc [2], hi_cyc [2], low_cyc [2];
    int          run [2], phase_err [2], csn_hi_run [2], csn_hi_before [2];
    int          acc_cnt [2], rsp_cnt [2], acc_edge [2], last_rsp_edge [2], acc_gap [2];
    logic [31:0] inw [2], last_data [2];
    logic [23:0] acc_addr [2];
    logic        pend [2], sck_prev [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            falls[i] = 0; rises[i] = 0; lo_cyc[i] = 0; hi_cyc[i] = 0; low_cyc[i] = 0;
            run[i] = 0; phase_err[i] = 0; csn_hi_run[i] = 0; csn_hi_before[i] = 0;
            acc_cnt[i] = 0; rsp_cnt[i] = 0; acc_edge[i] = 0; last_rsp_edge[i] = 0; acc_gap[i] = 0;
            inw[i] = '0; last_data[i] = '0; acc_addr[i] = '0; pend[i] = 1'b0; sck_prev[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [7:0]  byt;
                logic [23:0] ba;
                int          k;
                if (rst) begin
                    pend[i] = 1'b0;
                end else if (rv[i] && rdy[i]) begin
                    if (pend[i]) chk("overlap_accept", 1, 0);
                    pend[i]     = 1'b1;
                    acc_addr[i] = ra[i];
                    acc_edge[i] = cyc + 1;
                    acc_gap[i]  = acc_edge[i] - last_rsp_edge[i];
                    acc_cnt[i]++;
                    falls[i] = 0; rises[i] = 0; lo_cyc[i] = 0; hi_cyc[i] = 0;
                    low_cyc[i] = 0; phase_err[i] = 0; inw[i] = '0;
                end
                if (!csn[i]) begin
                    if (csn_hi_run[i] != 0) csn_hi_before[i] = csn_hi_run[i];
                    csn_hi_run[i] = 0;
                    low_cyc[i]++;
                    if (sck[i]) hi_cyc[i]++; else lo_cyc[i]++;
                    if (sck[i] == sck_prev[i]) begin
                        run[i]++;
                    end else begin
                        if (run[i] != cd_of(i)) phase_err[i]++;
                        run[i] = 1;
                    end
                    if (sck[i] && !sck_prev[i]) begin
                        rises[i]++;
                        if (rises[i] <= 32) inw[i] = {inw[i][30:0], sdo[i]};
                    end
                    if (!sck[i] && sck_prev[i]) falls[i]++;
                    if (falls[i] >= 32 && falls[i] < 64) begin
                        k   = falls[i] - 32;
                        ba  = inw[i][23:0] + 24'(k / 8);
                        byt = mem_b(ba);
                        sdi[i] = byt[7 - (k % 8)];
                    end else begin
                        sdi[i] = 1'($urandom);
                    end
                end else begin
                    csn_hi_run[i]++;
                    run[i] = 0;
                    sdi[i] = 1'b0;
                end
                sck_prev[i] = sck[i];
                if (rspv[i]) begin
                    rsp_cnt[i]++;
                    last_rsp_edge[i] = cyc;
                    last_data[i]     = rspd[i];
                    if (!pend[i]) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        chk("rsp_data",    rspd[i], exp_word(acc_addr[i]));
                        chk("latency",     cyc - acc_edge[i], 128 * cd_of(i) + 1);
                        chk("flash_cmd",   inw[i][31:24], 8'h03);
                        chk("flash_addr",  inw[i][23:0], acc_addr[i]);
                        chk("sck_rises",   rises[i], 64);
                        chk("csn_low_cyc", low_cyc[i], 128 * cd_of(i));
                        chk("sck_hi_cyc",  hi_cyc[i], 64 * cd_of(i));
                        chk("sck_lo_cyc",  lo_cyc[i], 64 * cd_of(i));
                        chk("sck_phase",   phase_err[i], 0);
                    end
                    pend[i] = 1'b0;
                end
            end
        end
    end

    task automatic start_req(input int i, input logic [23:0] a);
        int n;
        n = 0;
        while (!rdy[i] && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 2000) chk("ready_timeout", 0, 1);
        ra[i] = a;
        rv[i] = 1'b1;
        @(posedge clk); #2;
        rv[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input int target);
        int n;
        n = 0;
        while (rsp_cnt[i] < target && n < 5000) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 5000) chk("rsp_timeout", rsp_cnt[i], target);
    endtask

    initial begin
        int r0, a0, n;
        logic [23:0] addr;
        ra[0] = '0;
        ra[1] = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_csn",  csn[i], 1);
            chk("rst_sck",  sck[i], 0);
            chk("rst_sdo",  sdo[i], 0);
            chk("rst_rdy",  rdy[i], 1);
            chk("rst_rspv", rspv[i], 0);
            chk("rst_rspd", rspd[i], 0);
        end
        #1 rst = 1'b0;
        @(posedge clk); #2;

        // CLK_DIV=1, fixed address
        start_req(0, 24'h000010);
        wait_rsp(0, 1);
        chk("t2_data", last_data[0], 32'hB6B7B4B5);

        // CLK_DIV=3, wrapping address
        start_req(1, 24'hFFFFFE);
        wait_rsp(1, 1);
        chk("t3_data", last_data[1], 32'hA4A55A5B);

        // Randomized traffic on both controllers
        for (int t = 0; t < 6; t++) begin
            int ch;
            ch = t % 2;
            r0 = rsp_cnt[ch];
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #2;
            start_req(ch, 24'($urandom));
            wait_rsp(ch, r0 + 1);
        end

        // req_valid held high across two transfers
        r0 = rsp_cnt[0];
        a0 = acc_cnt[0];
        ra[0] = 24'($urandom);
        rv[0] = 1'b1;
        n = 0;
        while (acc_cnt[0] < a0 + 2 && n < 2000) begin
            @(posedge clk); #2;
            if (acc_cnt[0] == a0 + 1) ra[0] = 24'($urandom);
            n++;
        end
        rv[0] = 1'b0;
        chk("t4_accepts", acc_cnt[0] - a0, 2);
        chk("t4_gap", acc_gap[0], CS_GAP + 1);
        wait_rsp(0, r0 + 2);
        chk("t4_csn_high_min", csn_hi_before[0] >= CS_GAP + 1, 1);
        repeat (20) @(posedge clk);
        #2;
        chk("t4_rsp_count", rsp_cnt[0] - r0, 2);

        // Requests during SHIFT are ignored
        r0 = rsp_cnt[0];
        a0 = acc_cnt[0];
        start_req(0, 24'($urandom));
        for (int p = 0; p < 10; p++) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2;
            chk("t5_ready_low", rdy[0], 0);
            ra[0] = 24'($urandom);
            rv[0] = 1'b1;
            @(posedge clk); #2;
            rv[0] = 1'b0;
        end
        wait_rsp(0, r0 + 1);
        repeat (200) @(posedge clk);
        #2;
        chk("t5_rsp_count", rsp_cnt[0] - r0, 1);
        chk("t5_acc_count", acc_cnt[0] - a0, 1);

        // Reset in the middle of the data phase
        r0 = rsp_cnt[0];
        start_req(0, 24'($urandom));
        n = 0;
        while (falls[0] < 40 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("t6_bit40_timeout", falls[0], 40);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_csn", csn[0], 1);
        chk("t6_sck", sck[0], 0);
        chk("t6_sdo", sdo[0], 0);
        chk("t6_rdy", rdy[0], 1);
        rst = 1'b0;
        repeat (300) @(posedge clk);
        #2;
        chk("t6_no_rsp", rsp_cnt[0] - r0, 0);
        addr = 24'($urandom);
        start_req(0, addr);
        wait_rsp(0, r0 + 1);
        chk("t6_after_data", last_data[0], exp_word(addr));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
